// File: rtl/c499_enc_tx.sv
// c499_enc_tx: appends the eight c499 check bits to 32-bit data words and streams
// the 40-bit codewords out through a small FIFO. Optional check-bit obfuscation: C499_ENC_CHK_OBF_EN.
module c499_enc_tx #(
  parameter int OUT_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
`ifdef C499_ENC_CHK_OBF_EN
  input  logic             key_load,
  input  logic [15:0]      key_in,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [39:0]      out_code,
  output logic [CNT_W-1:0] sent_cnt
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_FW = PTR_W + 1;

  // Parity groups: each check bit covers one stride-4 column plus a half/quarter block.
  localparam logic [31:0] CHK_MASK0 = 32'h00FF_1111;
  localparam logic [31:0] CHK_MASK1 = 32'hFF00_2222;
  localparam logic [31:0] CHK_MASK2 = 32'h0F0F_4444;
  localparam logic [31:0] CHK_MASK3 = 32'hF0F0_8888;
  localparam logic [31:0] CHK_MASK4 = 32'h1111_00FF;
  localparam logic [31:0] CHK_MASK5 = 32'h2222_FF00;
  localparam logic [31:0] CHK_MASK6 = 32'h4444_0F0F;
  localparam logic [31:0] CHK_MASK7 = 32'h8888_F0F0;

  function automatic logic [7:0] chk_calc(input logic [31:0] d);
    logic [7:0] c;
    c[0] = ^(d & CHK_MASK0);
    c[1] = ^(d & CHK_MASK1);
    c[2] = ^(d & CHK_MASK2);
    c[3] = ^(d & CHK_MASK3);
    c[4] = ^(d & CHK_MASK4);
    c[5] = ^(d & CHK_MASK5);
    c[6] = ^(d & CHK_MASK6);
    c[7] = ^(d & CHK_MASK7);
    return c;
  endfunction

`ifdef C499_ENC_CHK_OBF_EN
  function automatic logic [7:0] obf_apply(input logic [7:0] chk, input logic [15:0] key);
    logic [7:0] r;
    r = chk;
    for (int k = 0; k < 8; k++) begin
      case ({key[2*k+1], key[2*k]})
        2'b00:   r[k] = chk[k];
        2'b10:   r[k] = ~chk[k];
        2'b01:   r[k] = 1'b1;
        2'b11:   r[k] = 1'b0;
        default: r[k] = chk[k];
      endcase
    end
    return r;
  endfunction
`endif

  logic              rdy_en_r;
  logic              s1_valid_r;
  logic [31:0]       s1_data_r;
  logic              ov_r;
  logic [39:0]       oc_r;
  logic [39:0]       fifo_mem_r [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_FW-1:0] count_r;
  logic [CNT_W-1:0]  sent_cnt_r;

  logic              send_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic              s1_adv_s;
  logic              direct_s;
  logic              fifo_push_s;
  logic              fifo_pop_s;
  logic              in_ready_s;
  logic              accept_s;
  logic [7:0]        chk_s;
  logic [39:0]       code_s;

`ifdef C499_ENC_CHK_OBF_EN
  logic [15:0]       key_r;
  logic [15:0]       s1_key_r;

  // Key register; the word accepted alongside a load keeps the previous key.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_r    <= 16'h0000;
      s1_key_r <= 16'h0000;
    end else begin
      if (key_load) begin
        key_r <= key_in;
      end else begin
        key_r <= key_r;
      end
      if (accept_s) begin
        s1_key_r <= key_r;
      end else begin
        s1_key_r <= s1_key_r;
      end
    end
  end
`endif

  // Handshake and flow control between stage 1, the output register and the FIFO.
  always_comb begin
    send_s       = ov_r & out_ready;
    fifo_empty_s = (count_r == {CNT_FW{1'b0}});
    fifo_full_s  = (count_r == CNT_FW'(OUT_DEPTH));
    // A full FIFO still takes a push when the head moves into the output register.
    s1_adv_s     = s1_valid_r & (~fifo_full_s | send_s);
    direct_s     = s1_adv_s & fifo_empty_s & (~ov_r | send_s);
    fifo_push_s  = s1_adv_s & ~direct_s;
    fifo_pop_s   = send_s & ~fifo_empty_s;
    in_ready_s   = rdy_en_r & (~s1_valid_r | s1_adv_s);
    accept_s     = in_valid & in_ready_s;
  end

  // Stage 2 codeword formation.
  always_comb begin
    chk_s = chk_calc(s1_data_r);
`ifdef C499_ENC_CHK_OBF_EN
    code_s = {obf_apply(chk_s, s1_key_r), s1_data_r};
`else
    code_s = {chk_s, s1_data_r};
`endif
  end

  // Stage 1 capture register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_en_r   <= 1'b0;
      s1_valid_r <= 1'b0;
      s1_data_r  <= 32'h0000_0000;
    end else begin
      rdy_en_r <= 1'b1;
      if (accept_s) begin
        s1_valid_r <= 1'b1;
        s1_data_r  <= in_data;
      end else if (s1_adv_s) begin
        s1_valid_r <= 1'b0;
        s1_data_r  <= s1_data_r;
      end else begin
        s1_valid_r <= s1_valid_r;
        s1_data_r  <= s1_data_r;
      end
    end
  end

  // FIFO storage and pointers behind the output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        fifo_mem_r[i] <= 40'h00_0000_0000;
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_FW{1'b0}};
    end else begin
      if (fifo_push_s) begin
        fifo_mem_r[wr_ptr_r] <= code_s;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (fifo_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({fifo_push_s, fifo_pop_s})
        2'b10:   count_r <= count_r + CNT_FW'(1);
        2'b01:   count_r <= count_r - CNT_FW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Output register: holds the head codeword until the downstream takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ov_r <= 1'b0;
      oc_r <= 40'h00_0000_0000;
    end else if (fifo_pop_s) begin
      ov_r <= 1'b1;
      oc_r <= fifo_mem_r[rd_ptr_r];
    end else if (direct_s) begin
      ov_r <= 1'b1;
      oc_r <= code_s;
    end else if (send_s) begin
      ov_r <= 1'b0;
      oc_r <= oc_r;
    end else begin
      ov_r <= ov_r;
      oc_r <= oc_r;
    end
  end

  // Sent-word counter, wrapping at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sent_cnt_r <= {CNT_W{1'b0}};
    end else if (send_s) begin
      sent_cnt_r <= sent_cnt_r + CNT_W'(1);
    end else begin
      sent_cnt_r <= sent_cnt_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = ov_r;
  assign out_code  = oc_r;
  assign sent_cnt  = sent_cnt_r;

endmodule

// File: tb/tb_c499_enc_tx.sv
// Self-checking bench for c499_enc_tx: directed vectors, backpressure, reset and a
// randomized ready/valid run against a queue-based reference model.
module tb_c499_enc_tx;
  localparam int OUT_DEPTH = 2;
  localparam int CNT_W     = 16;
  localparam int N_RAND    = 10000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = 32'h0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [39:0]      out_code;
  logic [CNT_W-1:0] sent_cnt;
`ifdef C499_ENC_CHK_OBF_EN
  logic             key_load = 1'b0;
  logic [15:0]      key_in = 16'h0;
  logic [15:0]      key_m = 16'h0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int snd_cnt = 0;
  logic [39:0] exp_q[$];
  logic [CNT_W-1:0] exp_sent = '0;

  c499_enc_tx #(.OUT_DEPTH(OUT_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef C499_ENC_CHK_OBF_EN
    .key_load(key_load), .key_in(key_in),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] span(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int b = lo; b <= hi; b++) m[b] = 1'b1;
    return m;
  endfunction

  // Check bits built from the listed bit sets: a stride-4 column plus block ranges.
  function automatic logic [7:0] ref_chk(input logic [31:0] d);
    logic [7:0] c;
    logic [31:0] set;
    int base;
    for (int k = 0; k < 8; k++) begin
      base = (k < 4) ? k : 12 + k;
      set = '0;
      for (int j = 0; j < 4; j++) set[base + 4*j] = 1'b1;
      case (k)
        0: set = set | span(16, 23);
        1: set = set | span(24, 31);
        2: set = set | span(16, 19) | span(24, 27);
        3: set = set | span(20, 23) | span(28, 31);
        4: set = set | span(0, 7);
        5: set = set | span(8, 15);
        6: set = set | span(0, 3) | span(8, 11);
        default: set = set | span(4, 7) | span(12, 15);
      endcase
      c[k] = ^(d & set);
    end
    return c;
  endfunction

  function automatic logic [39:0] ref_code(input logic [31:0] d);
    logic [7:0] c;
    c = ref_chk(d);
`ifdef C499_ENC_CHK_OBF_EN
    for (int k = 0; k < 8; k++) begin
      if (key_m[2*k+1] && !key_m[2*k]) c[k] = ~c[k];
      else if (!key_m[2*k+1] && key_m[2*k]) c[k] = 1'b1;
      else if (key_m[2*k+1] && key_m[2*k]) c[k] = 1'b0;
    end
`endif
    return {c, d};
  endfunction

  // Monitor / scoreboard, sampling on the falling edge.
  initial begin
    logic hold_pend;
    logic [39:0] hold_code;
    logic [39:0] e;
    hold_pend = 1'b0;
    hold_code = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_sent = '0;
        hold_pend = 1'b0;
`ifdef C499_ENC_CHK_OBF_EN
        key_m = 16'h0;
`endif
      end else begin
        check("sent_cnt", 64'(sent_cnt), 64'(exp_sent));
        if (hold_pend) begin
          check("hold_valid", 64'(out_valid), 64'(1'b1));
          check("hold_code", 64'(out_code), 64'(hold_code));
        end
        if (out_valid && out_ready) begin
          check("send_expected", 64'(exp_q.size() != 0), 64'(1'b1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("code", 64'(out_code), 64'(e));
          end
          exp_sent = exp_sent + 1'b1;
          snd_cnt++;
        end
        hold_pend = out_valid && !out_ready;
        hold_code = out_code;
        if (in_valid && in_ready) exp_q.push_back(ref_code(in_data));
`ifdef C499_ENC_CHK_OBF_EN
        if (key_load) key_m = key_in;
`endif
      end
    end
  end

  task automatic push(input logic [31:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 64'(in_ready), 64'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] dv[4] = '{32'h0000_0000, 32'h0000_0001, 32'h0001_0000, 32'hFFFF_FFFF};
    logic [7:0]  cv[4] = '{8'h00, 8'h51, 8'h15, 8'h00};
    int k, s0, words, cyc;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(1'b0));
    check("rst_in_ready", 64'(in_ready), 64'(1'b0));
    check("rst_out_code", 64'(out_code), 64'(40'h0));
    check("rst_sent_cnt", 64'(sent_cnt), 64'(16'h0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready_pre", 64'(in_ready), 64'(1'b0));
    @(negedge clk);
    check("rel_in_ready", 64'(in_ready), 64'(1'b1));
    @(posedge clk); #1;

    // Directed vectors and 2-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(dv[i]);
      @(negedge clk);
      check("lat1_valid", 64'(out_valid), 64'(1'b0));
      @(negedge clk);
      check("lat2_valid", 64'(out_valid), 64'(1'b1));
      check("lat2_code", 64'(out_code), 64'({cv[i], dv[i]}));
      @(posedge clk); #1;
    end

`ifdef C499_ENC_CHK_OBF_EN
    // Key obfuscation
    key_in = 16'h0002; key_load = 1'b1;
    @(posedge clk); #1 key_load = 1'b0;
    push(32'h0000_0001);
    @(negedge clk); @(negedge clk);
    check("obf_key2_chk", 64'(out_code[39:32]), 64'(8'h50));
    @(posedge clk); #1;
    key_in = 16'h0000; key_load = 1'b1;
    push(32'h0000_0001);
    key_load = 1'b0;
    @(negedge clk); @(negedge clk);
    check("obf_concurrent_chk", 64'(out_code[39:32]), 64'(8'h50));
    @(posedge clk); #1;
    push(32'h0000_0001);
    @(negedge clk); @(negedge clk);
    check("obf_key0_chk", 64'(out_code[39:32]), 64'(8'h51));
    @(posedge clk); #1;
`endif

    // Backpressure: 5 back-to-back words with the downstream stalled
    out_ready = 1'b0;
    s0 = snd_cnt;
    k = 0;
    in_valid = 1'b1;
    in_data = 32'hA500_0000;
    repeat (8) begin
      @(negedge clk);
      if (in_ready) k++;
      @(posedge clk); #1;
      in_data = 32'hA500_0000 + 32'(k);
    end
    check("bp_accepted", 64'(k), 64'(OUT_DEPTH + 2));
    @(negedge clk);
    check("bp_in_ready", 64'(in_ready), 64'(1'b0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    cyc = 0;
    while (k < 5 && cyc < 50) begin
      @(negedge clk);
      if (in_ready) k++;
      @(posedge clk); #1;
      in_data = 32'hA500_0000 + 32'(k);
      cyc++;
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("bp_drained", 64'(snd_cnt - s0), 64'(5));

    // Reset with words in flight
    out_ready = 1'b0;
    push(32'h1111_1111);
    push(32'h2222_2222);
    push(32'h3333_3333);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'(1'b0));
    check("mid_rst_sent_cnt", 64'(sent_cnt), 64'(16'h0));
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    s0 = snd_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("mid_rst_no_stale", 64'(snd_cnt - s0), 64'(0));

    // Randomized ready/valid run
    s0 = snd_cnt;
    words = 0;
    cyc = 0;
    while ((snd_cnt - s0) < N_RAND && cyc < 80000) begin
      in_valid  = (words < N_RAND) && ($urandom_range(3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(2) != 0);
`ifdef C499_ENC_CHK_OBF_EN
      key_load  = ($urandom_range(15) == 0);
      key_in    = 16'($urandom);
`endif
      @(negedge clk);
      if (in_valid && in_ready) words++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
`ifdef C499_ENC_CHK_OBF_EN
    key_load = 1'b0;
`endif
    check("rand_sent", 64'(snd_cnt - s0), 64'(N_RAND));
    @(negedge clk);
    check("rand_sent_cnt", 64'(sent_cnt), 64'(N_RAND % (1 << CNT_W)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
